uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Frame-level round-robin arbiter that lets up to NREQ byte producers share the single transmit-FIFO write port of one `uart` instance. Each producer streams bytes with a valid/ack handshake and marks the final byte of a frame with `last`. The arbiter locks the port to one producer for a whole frame, so frames never interleave on the serial line, and it revokes a stalled lock after a timeout. It sits between the producers and the `uart` signals `wr_uart`, `w_data` and `tx_full`.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1024: number of owner-idle cycles before a lock is revoked. Must be at least 2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high. One clock; all state is updated on the rising edge of `clk`.
- `req` in NREQ: per-requester byte valid.
- `last` in NREQ: per-requester end-of-frame flag, qualified by `req`.
- `data` in NREQ*8: requester i's byte is `data[8*i+7:8*i]`.
- `ack` out NREQ: byte accepted this cycle (combinational).
- `gnt` out NREQ: one-hot frame owner (registered).
- `abort` out NREQ: one-cycle pulse, the owner's lock was revoked by timeout (registered).
- `busy` out 1: a lock is held (registered).
- `wr_uart` out 1: write strobe to the uart TX FIFO (combinational).
- `w_data` out 8: byte to the uart TX FIFO (combinational).
- `tx_full` in 1: uart TX FIFO full.

## Operation
- State machine has two states, IDLE and LOCK. It also keeps:
  - a round-robin pointer `ptr` of clog2(NREQ) bits;
  - an owner index `own`;
  - an idle counter `idc` of clog2(TIMEOUT) bits.
- In IDLE with any `req` bit high:
  - select the first set bit scanning `ptr`, `ptr+1`, … modulo NREQ;
  - load `own`, set `gnt[own]`, clear `idc`, and go to LOCK.
  - `req` bits are don't-care in IDLE for data purposes; no ack is given in IDLE.
- In LOCK, a write occurs when `req[own]` is high and `tx_full` is low. On a write:
  - `wr_uart`=1, `w_data`=`data[own]`, `ack[own]`=1;
  - all other `ack` bits are 0.
- A write with `last[own]`=1 ends the frame:
  - next cycle the state is IDLE, `gnt`=0, and `ptr`=`own`+1 modulo NREQ.
- `idc` behaviour in LOCK:
  - increments on every cycle with `req[own]`=0;
  - clears on any write;
  - holds when `req[own]`=1 and `tx_full`=1 (backpressure is never a timeout).
- If `req[own]`=0 while `idc`==TIMEOUT-1:
  - next cycle `abort[own]` pulses, `gnt`=0, state IDLE, `ptr`=`own`+1.
- Requests from non-owners are ignored while a lock is held; their `ack` stays 0.
- A single-byte frame (`last`=1 on the first byte) is legal.
- If `tx_full` is high, a `last` byte is not accepted and the frame is not ended; this is ordinary stall behaviour.
- `rst` at any time, including mid-frame:
  - state IDLE, `ptr`=0, `own`=0, `idc`=0;
  - `gnt`=0, `abort`=0, `busy`=0, and therefore `ack`=0 and `wr_uart`=0;
  - `w_data` is don't-care while `wr_uart`=0.
  - Bytes already written to the FIFO are not recalled.

## Timing
- Grant latency: `req` seen in IDLE at cycle N gives `gnt` at N+1; the earliest write is at N+1.
- Throughput: one byte per cycle while `req[own]`=1 and `tx_full`=0.
- Release: `last` accepted at cycle M gives IDLE at M+1; the next grant is at M+2. There is a one-cycle bubble between frames.
- Timeout: the owner deasserts `req` at cycle K with no further writes, so `abort` is high at cycle K+TIMEOUT, and only for that cycle.
- `busy` equals `|gnt`.

## Structure
- Shared package `uart_arb_pkg`: state encoding constants (IDLE, LOCK) and default values for NREQ and TIMEOUT.
- One sub-module, `uart_rr_pick`: a combinational rotating priority encoder.
  - Inputs: `req`[NREQ] and `ptr`.
  - Outputs: `idx` and `any`.
  - Reused by future arbiters in the same design.

## Test plan
- Reset then single requester:
  - `req[2]` sends 0x41, 0x42, 0x43 with `last` on 0x43 and `tx_full`=0;
  - `gnt`=0100 at cycle 1;
  - `wr_uart` high for 3 consecutive cycles with `w_data` 41/42/43;
  - `gnt`=0 on the cycle after 0x43.
- Fairness: all four `req` held with 2-byte frames and `ptr`=0.
  - Grant order is 0,1,2,3,0.
  - Each pair of bytes is contiguous on `w_data`.
  - There is exactly one idle cycle between frames.
- Backpressure: `tx_full`=1 for 20 cycles mid-frame with owner `req` high.
  - No `wr_uart` or `ack` during the stall.
  - No `abort`, even with `TIMEOUT`=8.
  - Transfer resumes on the cycle `tx_full` falls.
- Timeout with `TIMEOUT`=8: owner 1 sends 0x10, then drops `req` at cycle K.
  - `abort`=0010 at K+8 only.
  - `gnt`=0 at K+8.
  - A pending `req[3]` is granted at K+9.
- Reset mid-frame: assert `rst` while owner 0 is streaming.
  - On the next cycle `gnt`, `ack`, `wr_uart`, `busy` and `abort` are all 0.
  - After release, `req[1]` and `req[0]` together grant 0 (because `ptr`=0).

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared definitions for the uart transmit arbiters: FSM state encoding
//   and default sizing parameters.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
//   Combinational rotating priority encoder. Returns the first set bit of
//   req, scanning ptr, ptr+1, ... modulo NREQ.
// Ports:
//   req [NREQ]        request vector
//   ptr [clog2(NREQ)] highest-priority position
//   idx [clog2(NREQ)] selected requester (valid when any=1)
//   any               at least one req bit set
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  // Scan from the lowest priority upward so the last hit (highest priority) wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        idx = PW'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Frame-level round-robin arbiter sharing one uart TX FIFO write port
//   between NREQ byte producers. A grant locks the port for a whole frame
//   (until a byte with last=1 is written) or until the owner has been idle
//   for TIMEOUT cycles, in which case the lock is revoked with an abort pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req/last [NREQ]   per-requester byte valid / end-of-frame flag
//   data [NREQ*8]     per-requester byte, requester i at data[8*i+:8]
//   ack  [NREQ]       byte accepted this cycle (combinational)
//   gnt  [NREQ]       one-hot frame owner (registered)
//   abort [NREQ]      one-cycle pulse on timeout revocation (registered)
//   busy              lock held (registered)
//   wr_uart, w_data   uart TX FIFO write strobe / byte (combinational)
//   tx_full           uart TX FIFO full
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   last,
  input  logic [NREQ*8-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   abort,
  output logic              busy,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  input  logic              tx_full
);

  localparam int PW = $clog2(NREQ);
  localparam int IW = $clog2(TIMEOUT);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] own_q, own_d;
  logic [IW-1:0] idc_q, idc_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] abort_q, abort_d;
  logic          busy_q, busy_d;

  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic          wr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] o);
    return (int'(o) == NREQ - 1) ? '0 : o + 1'b1;
  endfunction

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // A write needs the lock, the owner's byte and room in the FIFO.
  assign wr      = (state_q == LOCK) && req[own_q] && !tx_full;
  assign wr_uart = wr;
  assign w_data  = data[8*own_q +: 8];
  assign ack     = wr ? (NREQ'(1) << own_q) : '0;

  assign gnt   = gnt_q;
  assign abort = abort_q;
  assign busy  = busy_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    idc_d   = idc_q;
    gnt_d   = gnt_q;
    abort_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          own_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          idc_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (wr) begin
          idc_d = '0;
          if (last[own_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = next_ptr(own_q);
          end
        end else if (!req[own_q]) begin
          // Only an absent owner counts towards the timeout; a full FIFO holds idc.
          if (idc_q == IW'(TIMEOUT - 1)) begin
            abort_d = NREQ'(1) << own_q;
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = next_ptr(own_q);
          end else begin
            idc_d = idc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      idc_q   <= '0;
      gnt_q   <= '0;
      abort_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      idc_q   <= idc_d;
      gnt_q   <= gnt_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed self-checking bench for uart_tx_arbiter (NREQ=4, TIMEOUT=8).
//   Inputs change 1 ns after each rising edge; outputs are sampled 3 ns
//   after the edge.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic [3:0]  abort;
  logic        busy;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        tx_full;

  int n_cmp = 0;
  int n_err = 0;

  // Round-robin fairness with four 2-byte frames: expected gnt/ack per cycle
  // and the byte written in that cycle (0 where no write is expected).
  int fair_gnt [15] = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1, 1};
  int fair_wd  [15] = '{0, 'h10, 'h11, 0, 'h20, 'h21, 0, 'h30, 'h31, 0,
                        'h40, 'h41, 0, 'h10, 'h11};

  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .last    (last),
    .data    (data),
    .ack     (ack),
    .gnt     (gnt),
    .abort   (abort),
    .busy    (busy),
    .wr_uart (wr_uart),
    .w_data  (w_data),
    .tx_full (tx_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input int i, input logic r, input logic l, input logic [7:0] d);
    req[i]        = r;
    last[i]       = l;
    data[8*i +: 8] = d;
  endtask

  task automatic all_idle(input string tag);
    check_eq({tag, "_gnt"},   32'(gnt),     32'h0);
    check_eq({tag, "_ack"},   32'(ack),     32'h0);
    check_eq({tag, "_wr"},    32'(wr_uart), 32'h0);
    check_eq({tag, "_busy"},  32'(busy),    32'h0);
    check_eq({tag, "_abort"}, 32'(abort),   32'h0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    last    = '0;
    data    = '0;
    tx_full = 1'b0;
    cyc();
    settle();
    all_idle("rst");
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_write(input string tag, input logic [3:0] g, input logic [7:0] d);
    check_eq({tag, "_gnt"}, 32'(gnt),     32'(g));
    check_eq({tag, "_wr"},  32'(wr_uart), 32'h1);
    check_eq({tag, "_wd"},  32'(w_data),  32'(d));
    check_eq({tag, "_ack"}, 32'(ack),     32'(g));
  endtask

  initial begin
    logic cnt [4];
    logic [7:0] b;

    // ---------------- reset, then single requester 2
    do_reset();
    cyc(); drive(2, 1'b1, 1'b0, 8'h41); settle();
    check_eq("t1_c0_gnt", 32'(gnt), 32'h0);
    check_eq("t1_c0_wr",  32'(wr_uart), 32'h0);
    check_eq("t1_c0_ack", 32'(ack), 32'h0);
    cyc(); settle();
    chk_write("t1_c1", 4'b0100, 8'h41);
    check_eq("t1_c1_busy", 32'(busy), 32'h1);
    cyc(); drive(2, 1'b1, 1'b0, 8'h42); settle();
    chk_write("t1_c2", 4'b0100, 8'h42);
    cyc(); drive(2, 1'b1, 1'b1, 8'h43); settle();
    chk_write("t1_c3", 4'b0100, 8'h43);
    cyc(); drive(2, 1'b0, 1'b0, 8'h00); settle();
    all_idle("t1_c4");

    // ---------------- fairness: all four requesters, 2-byte frames
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      cyc();
      for (int i = 0; i < 4; i++) drive(i, 1'b1, cnt[i], 8'((i + 1) * 16 + int'(cnt[i])));
      settle();
      check_eq($sformatf("fair_c%0d_gnt", c), 32'(gnt), 32'(fair_gnt[c]));
      check_eq($sformatf("fair_c%0d_ack", c), 32'(ack), 32'(fair_gnt[c]));
      check_eq($sformatf("fair_c%0d_wr", c), 32'(wr_uart), 32'(fair_gnt[c] != 0));
      if (fair_gnt[c] != 0)
        check_eq($sformatf("fair_c%0d_wd", c), 32'(w_data), 32'(fair_wd[c]));
      for (int i = 0; i < 4; i++) if (ack[i]) cnt[i] = ~cnt[i];
    end
    cyc(); req = '0; last = '0; settle();
    all_idle("fair_end");

    // ---------------- reset mid-frame (ptr is 1 here, reset must clear it)
    cyc(); drive(0, 1'b1, 1'b0, 8'h50); settle();
    check_eq("t5_c0_gnt", 32'(gnt), 32'h0);
    cyc(); settle();
    chk_write("t5_c1", 4'b0001, 8'h50);
    cyc(); drive(0, 1'b1, 1'b0, 8'h51); rst = 1'b1; settle();
    chk_write("t5_c2", 4'b0001, 8'h51);
    cyc(); rst = 1'b0; drive(1, 1'b1, 1'b0, 8'h61); settle();
    all_idle("t5_c3");
    cyc(); settle();
    chk_write("t5_c4", 4'b0001, 8'h51);

    // ---------------- backpressure: 20 stalled cycles with TIMEOUT=8
    do_reset();
    cyc(); drive(1, 1'b1, 1'b0, 8'hA0); settle();
    check_eq("bp_c0_gnt", 32'(gnt), 32'h0);
    cyc(); settle();
    chk_write("bp_c1", 4'b0010, 8'hA0);
    cyc(); drive(1, 1'b1, 1'b0, 8'hA1); settle();
    chk_write("bp_c2", 4'b0010, 8'hA1);
    cyc(); drive(1, 1'b1, 1'b0, 8'hA2); tx_full = 1'b1;
    for (int k = 0; k < 20; k++) begin
      settle();
      check_eq($sformatf("bp_s%0d_wr", k),    32'(wr_uart), 32'h0);
      check_eq($sformatf("bp_s%0d_ack", k),   32'(ack),     32'h0);
      check_eq($sformatf("bp_s%0d_abort", k), 32'(abort),   32'h0);
      check_eq($sformatf("bp_s%0d_gnt", k),   32'(gnt),     32'h2);
      cyc();
    end
    tx_full = 1'b0; settle();
    chk_write("bp_resume", 4'b0010, 8'hA2);
    cyc(); drive(1, 1'b1, 1'b1, 8'hA3); settle();
    chk_write("bp_last", 4'b0010, 8'hA3);
    cyc(); drive(1, 1'b0, 1'b0, 8'h00); settle();
    all_idle("bp_end");

    // ---------------- timeout: owner 1 stalls, requester 3 waits
    do_reset();
    cyc(); drive(1, 1'b1, 1'b0, 8'h10); drive(3, 1'b1, 1'b1, 8'h33); settle();
    check_eq("to_c0_gnt", 32'(gnt), 32'h0);
    cyc(); settle();
    chk_write("to_c1", 4'b0010, 8'h10);
    cyc(); drive(1, 1'b0, 1'b0, 8'h00);   // cycle K
    for (int j = 0; j < 8; j++) begin
      settle();
      check_eq($sformatf("to_k%0d_abort", j), 32'(abort), 32'h0);
      check_eq($sformatf("to_k%0d_gnt", j),   32'(gnt),   32'h2);
      check_eq($sformatf("to_k%0d_ack", j),   32'(ack),   32'h0);
      cyc();
    end
    settle();                               // cycle K+8
    check_eq("to_k8_abort", 32'(abort), 32'h2);
    check_eq("to_k8_gnt",   32'(gnt),   32'h0);
    check_eq("to_k8_busy",  32'(busy),  32'h0);
    check_eq("to_k8_wr",    32'(wr_uart), 32'h0);
    cyc(); settle();                        // cycle K+9
    check_eq("to_k9_abort", 32'(abort), 32'h0);
    chk_write("to_k9", 4'b1000, 8'h33);
    cyc(); drive(3, 1'b0, 1'b0, 8'h00); settle();
    all_idle("to_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
